// File: rtl/data_mem_responder.sv
// Memory-stage data responder: byte-lane stores into a word RAM and lane-aligned
// loads returned after LATENCY cycles, with the pipeline held via stall_o meanwhile.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2,
    localparam int AW         = $clog2(DEPTH_WORDS)
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        req_valid_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] write_data_i,
    input  logic        mem_write_i,
    input  logic [2:0]  width_src_i,
    output logic [31:0] read_data_o,
    output logic        stall_o,
    output logic        misaligned_o
);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t        state;
    logic [2:0]    cnt;
    logic [31:0]   rd_q;
    logic [31:0]   mem [DEPTH_WORDS];

    logic [AW-1:0] idx;
    logic          is_half, is_byte, is_word;
    logic          misaligned;
    logic          do_store, load_acc;
    logic [3:0]    be;
    logic [31:0]   wdata;
    logic [31:0]   shifted;
    logic          unused_addr;

    assign idx         = addr_i[AW+1:2];
    assign unused_addr = ^addr_i[31:AW+2];

    assign is_half = (width_src_i == 3'b010) || (width_src_i == 3'b011);
    assign is_byte = (width_src_i == 3'b100) || (width_src_i == 3'b101);
    assign is_word = !is_half && !is_byte;

    assign misaligned   = (is_half && addr_i[0]) || (is_word && (addr_i[1:0] != 2'b00));
    assign misaligned_o = req_valid_i && misaligned;

    assign do_store = req_valid_i && mem_write_i && !misaligned && !reset_i;
    assign load_acc = req_valid_i && !mem_write_i && !misaligned && (state == IDLE);

    always_comb begin
        be    = 4'b1111;
        wdata = write_data_i;
        if (is_half) begin
            be    = 4'b0011 << addr_i[1:0];
            wdata = {2{write_data_i[15:0]}};
        end else if (is_byte) begin
            be    = 4'b0001 << addr_i[1:0];
            wdata = {4{write_data_i[7:0]}};
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_store) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    // Word loads are always aligned here, so the shift only matters for byte/half.
    assign shifted = mem[idx] >> {addr_i[1:0], 3'b000};

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state <= IDLE;
            cnt   <= 3'd0;
            rd_q  <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (load_acc) begin
                        rd_q  <= shifted;
                        cnt   <= 3'(LATENCY - 1);
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt != 3'd0) begin
                        rd_q <= shifted;
                        cnt  <= cnt - 3'd1;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign stall_o = !reset_i && (((state == IDLE) && load_acc) ||
                                  ((state == WAIT) && (cnt != 3'd0)));

    // A misaligned load is dropped and returns zero in its own cycle.
    assign read_data_o = (req_valid_i && !mem_write_i && misaligned && (state == IDLE))
                         ? 32'd0 : rd_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: four instances at LATENCY 1/2/4/7 driven by
// directed and random loads/stores, checked against a byte-level memory model.
`timescale 1ns/1ps
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid [4];
    logic [31:0] addr      [4];
    logic [31:0] wdata     [4];
    logic        mem_write [4];
    logic [2:0]  width     [4];
    logic [31:0] rdata     [4];
    logic        stall     [4];
    logic        mis       [4];

    logic [31:0] model [4][1024];
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    function automatic int lat_of(int k);
        case (k)
            0:       return 1;
            1:       return 2;
            2:       return 4;
            default: return 7;
        endcase
    endfunction

    for (genvar g = 0; g < 4; g++) begin : g_dut
        data_mem_responder #(
            .DEPTH_WORDS(1024),
            .LATENCY    (g == 0 ? 1 : g == 1 ? 2 : g == 2 ? 4 : 7)
        ) u_dut (
            .clk_i       (clk),
            .reset_i     (reset),
            .req_valid_i (req_valid[g]),
            .addr_i      (addr[g]),
            .write_data_i(wdata[g]),
            .mem_write_i (mem_write[g]),
            .width_src_i (width[g]),
            .read_data_o (rdata[g]),
            .stall_o     (stall[g]),
            .misaligned_o(mis[g])
        );
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Access size in bytes from the width code.
    function automatic int size_of(logic [2:0] ws);
        if (ws == 3'd2 || ws == 3'd3) return 2;
        if (ws == 3'd4 || ws == 3'd5) return 1;
        return 4;
    endfunction

    function automatic logic is_mis(logic [31:0] a, logic [2:0] ws);
        int sz = size_of(ws);
        return (sz == 2 && (a % 2) != 0) || (sz == 4 && (a % 4) != 0);
    endfunction

    function automatic int widx(logic [31:0] a);
        return int'((a >> 2) % 1024);
    endfunction

    task automatic model_store(input int k, input logic [31:0] a, input logic [31:0] d,
                               input logic [2:0] ws);
        int off = int'(a % 4);
        int sz  = size_of(ws);
        int w   = widx(a);
        for (int b = off; b < off + sz; b++)
            model[k][w][8*b +: 8] = d[8*(b-off) +: 8];
    endtask

    task automatic op_start(input int k, input logic [31:0] a, input logic [31:0] d,
                            input logic wr, input logic [2:0] ws);
        @(negedge clk);
        foreach (req_valid[i]) req_valid[i] = 1'b0;
        req_valid[k] = 1'b1;
        addr[k]      = a;
        wdata[k]     = d;
        mem_write[k] = wr;
        width[k]     = ws;
        #1;
    endtask

    task automatic do_store(input int k, input logic [31:0] a, input logic [31:0] d,
                            input logic [2:0] ws);
        logic m = is_mis(a, ws);
        op_start(k, a, d, 1'b1, ws);
        chk("st_misaligned", {31'd0, mis[k]}, {31'd0, m});
        chk("st_stall", {31'd0, stall[k]}, 32'd0);
        if (!m) model_store(k, a, d, ws);
    endtask

    task automatic do_load(input int k, input logic [31:0] a, input logic [2:0] ws,
                           output logic [31:0] got);
        logic        m   = is_mis(a, ws);
        logic [31:0] exp = model[k][widx(a)] >> (8 * (a % 4));
        op_start(k, a, 32'd0, 1'b0, ws);
        chk("ld_misaligned", {31'd0, mis[k]}, {31'd0, m});
        if (m) begin
            chk("ld_mis_stall", {31'd0, stall[k]}, 32'd0);
            chk("ld_mis_data", rdata[k], 32'd0);
            got = rdata[k];
            return;
        end
        for (int i = 0; i < lat_of(k); i++) begin
            if (i > 0) begin
                @(negedge clk);
                #1;
            end
            chk("ld_stall", {31'd0, stall[k]}, 32'd1);
        end
        @(negedge clk);
        #1;
        chk("ld_done_stall", {31'd0, stall[k]}, 32'd0);
        chk("ld_data", rdata[k], exp);
        got = rdata[k];
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] got;
        reset = 1'b1;
        foreach (req_valid[i]) begin
            req_valid[i] = 1'b1;
            addr[i]      = 32'h0;
            wdata[i]     = 32'h0;
            mem_write[i] = 1'b0;
            width[i]     = 3'd0;
        end
        repeat (2) begin
            @(negedge clk);
            #1;
            for (int k = 0; k < 4; k++) begin
                chk("rst_stall", {31'd0, stall[k]}, 32'd0);
                chk("rst_rdata", rdata[k], 32'd0);
                chk("rst_misaligned", {31'd0, mis[k]}, 32'd0);
            end
        end
        @(negedge clk);
        reset = 1'b0;
        foreach (req_valid[i]) req_valid[i] = 1'b0;

        for (int k = 0; k < 4; k++)
            for (int w = 0; w < 32; w++)
                do_store(k, 32'(w * 4), $urandom, 3'd0);

        // Word, byte and half lanes on the LATENCY=2 instance.
        do_store(1, 32'h40, 32'hDEADBEEF, 3'd0);
        do_load(1, 32'h40, 3'd0, got);
        chk("word_literal", got, 32'hDEADBEEF);
        do_store(1, 32'h43, 32'h00000011, 3'd4);
        do_store(1, 32'h40, 32'h00002233, 3'd2);
        do_load(1, 32'h40, 3'd0, got);
        chk("lanes_literal", got, 32'h11AD2233);
        do_load(1, 32'h43, 3'd5, got);
        chk("byte_literal", got & 32'hFF, 32'h11);
        do_load(1, 32'h42, 3'd3, got);
        chk("half_literal", got & 32'hFFFF, 32'h11AD);
        do_store(1, 32'h41, 32'hFFFFFFFF, 3'd0);
        do_load(1, 32'h40, 3'd0, got);
        chk("mis_store_nowrite", got, 32'h11AD2233);
        do_load(1, 32'h43, 3'd2, got);

        // Address wrap across every latency.
        for (int k = 0; k < 4; k++) begin
            do_store(k, 32'h1000, 32'h5A5A5A5A, 3'd0);
            do_load(k, 32'h0, 3'd0, got);
            chk("wrap_literal", got, 32'h5A5A5A5A);
        end

        // Reset in the middle of a LATENCY=4 load.
        op_start(2, 32'h8, 32'd0, 1'b0, 3'd0);
        chk("mid_stall_t0", {31'd0, stall[2]}, 32'd1);
        @(negedge clk);
        #1;
        chk("mid_stall_t1", {31'd0, stall[2]}, 32'd1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("mid_stall_rst", {31'd0, stall[2]}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        foreach (req_valid[i]) req_valid[i] = 1'b0;
        #1;
        chk("mid_stall_after", {31'd0, stall[2]}, 32'd0);
        chk("mid_rdata_after", rdata[2], 32'd0);
        do_load(2, 32'h8, 3'd0, got);

        for (int n = 0; n < 400; n++) begin
            int          k  = int'($urandom_range(0, 3));
            logic [31:0] a  = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 127));
            logic [2:0]  ws = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 1) do_store(k, a, $urandom, ws);
            else                           do_load(k, a, ws, got);
        end

        @(negedge clk);
        foreach (req_valid[i]) req_valid[i] = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
